serial_add_ctrl: RTL and testbench

- Bit-serial addition controller that owns and sequences one external 1-bit full adder to add two WIDTH-bit operands, one bit per clock.
- Accepts operands on a start pulse and walks them LSB-first through the adder.
- Holds the running carry in a flip-flop and assembles the sum in a shift register.
- Reports the result with a busy/done handshake. Sits between the lab top level (switches/buttons) and the 1-bit adder cell.

---
 rtl/serial_add_if.sv | 28 ++
 rtl/serial_add_ctrl.sv | 93 +++++++++
 tb/tb_serial_add_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_add_if.sv
// Handshake and 1-bit adder signals between the lab top level and the serial add controller.
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  modport slave (
    input  start, a, b, cin, fa_sum, fa_cout,
    output fa_a, fa_b, fa_cin, sum, cout, busy, done
  );

  modport master (
    output start, a, b, cin, fa_sum, fa_cout,
    input  fa_a, fa_b, fa_cin, sum, cout, busy, done
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks two operands LSB-first through an external
// 1-bit full adder, keeping the carry in a flop and assembling the sum in a shifter.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;

  assign run = (state_q == RUN);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {bus.fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = bus.fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        // The edge with cnt at WIDTH-1 handles the MSB, so the result is complete here
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = sum_sh_d;
          cout_d  = bus.fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Adder inputs are forced low outside RUN so the cell sees a quiet bus when idle
  assign bus.fa_a   = run & a_sh_q[0];
  assign bus.fa_b   = run & b_sh_q[0];
  assign bus.fa_cin = run & carry_q;
  assign bus.sum    = sum_q;
  assign bus.cout   = cout_q;
  assign bus.busy   = run;
  assign bus.done   = (state_q == DONE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural 1-bit full adder on the fa_* lines.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_add_if #(.WIDTH(WIDTH)) ifc ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  assign ifc.fa_sum  = ifc.fa_a ^ ifc.fa_b ^ ifc.fa_cin;
  assign ifc.fa_cout = (ifc.fa_a & ifc.fa_b) | (ifc.fa_a & ifc.fa_cin) | (ifc.fa_b & ifc.fa_cin);

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   done_count = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passes++;
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (ifc.done === 1'b1) begin
      exp_t e;
      done_count++;
      check("done_not_back_to_back", {63'd0, prev_done}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sum", {56'd0, ifc.sum}, {56'd0, e.sum});
        check("cout", {63'd0, ifc.cout}, {63'd0, e.cout});
        check("done_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_done = ifc.done;
  end

  task automatic push_exp(input logic [WIDTH-1:0] s, input logic c, input int at);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Issues a one-cycle start; returns 1 ns after the accepting edge
  task automatic start_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                           input logic cv, input logic push,
                           input logic [WIDTH-1:0] es, input logic ec);
    @(posedge clk); #1;
    ifc.a     = av;
    ifc.b     = bv;
    ifc.cin   = cv;
    ifc.start = 1'b1;
    if (push) push_exp(es, ec, cyc + 1 + WIDTH);
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d cycles, expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    int dc;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    ifc.cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sum", {56'd0, ifc.sum}, 64'd0);
    check("reset_ctrl_busy_done_cout", {61'd0, ifc.busy, ifc.done, ifc.cout}, 64'd0);
    rst = 1'b0;

    // Basic add with busy window
    start_add(8'h3C, 8'h5A, 1'b0, 1'b1, 8'h96, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check("busy_during_run", {63'd0, ifc.busy}, 64'd1);
    end
    @(negedge clk);
    check("busy_low_in_done", {62'd0, ifc.busy, ifc.done}, 64'd1);

    // Wrap-around
    start_add(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
    repeat (WIDTH + 3) @(posedge clk);
    start_add(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1);
    repeat (WIDTH + 3) @(posedge clk);

    // Start pulses during RUN must be ignored
    dc = done_count;
    start_add(8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    ifc.a     = 8'hAA;
    ifc.b     = 8'hAA;
    ifc.cin   = 1'b1;
    ifc.start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (8) @(posedge clk);
    check("single_done_with_busy_start", 64'(done_count - dc), 64'd1);

    // Reset in the middle of an add aborts it
    start_add(8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_sum", {56'd0, ifc.sum}, 64'd0);
    check("abort_cout_busy", {62'd0, ifc.cout, ifc.busy}, 64'd0);
    check("abort_fa_lines", {61'd0, ifc.fa_a, ifc.fa_b, ifc.fa_cin}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dc = done_count;
    repeat (12) @(posedge clk);
    check("no_done_after_abort", 64'(done_count - dc), 64'd0);
    start_add(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0);
    repeat (WIDTH + 3) @(posedge clk);

    // Back-to-back with start held high: accepts every WIDTH+2 clocks
    @(posedge clk); #1;
    ifc.a     = 8'h10;
    ifc.b     = 8'h20;
    ifc.cin   = 1'b0;
    ifc.start = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(8'h30, 1'b0, cyc + 1 + WIDTH + k * (WIDTH + 2));
    repeat (3 * (WIDTH + 2) - 1) @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (4) @(posedge clk);

    // Idle hygiene after a fresh reset
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {59'd0, ifc.busy, ifc.done, ifc.fa_a, ifc.fa_b, ifc.fa_cin}, 64'd0);
    end
    check("idle_sum_cleared", {55'd0, ifc.cout, ifc.sum}, 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
